// File: rtl/commit_trace_if.sv
// Commit-stream / trace-sink signal bundle for commit_trace_buffer.
// Carries trace_cycle only when TRACE_TIMESTAMP_EN is defined.
interface commit_trace_if #(
  parameter int CNT_W = 32
);
  logic             commit_valid;
  logic [31:0]      commit_pc;
  logic [31:0]      commit_instr;
  logic             wb_wreg;
  logic [4:0]       wb_wd;
  logic [31:0]      wb_wdata;
  logic             trace_valid;
  logic             trace_ready;
  logic [31:0]      trace_pc;
  logic [31:0]      trace_instr;
  logic             trace_wen;
  logic [4:0]       trace_wd;
  logic [31:0]      trace_wdata;
  logic             commit_stall;
  logic             overflow;
  logic [15:0]      drop_cnt;
  logic [CNT_W-1:0] retired_cnt;
`ifdef TRACE_TIMESTAMP_EN
  logic [63:0]      trace_cycle;
`endif

  modport master (
    output commit_valid, commit_pc, commit_instr, wb_wreg, wb_wd, wb_wdata, trace_ready,
    input  trace_valid, trace_pc, trace_instr, trace_wen, trace_wd, trace_wdata,
    input  commit_stall, overflow, drop_cnt, retired_cnt
`ifdef TRACE_TIMESTAMP_EN
    , input trace_cycle
`endif
  );

  modport slave (
    input  commit_valid, commit_pc, commit_instr, wb_wreg, wb_wd, wb_wdata, trace_ready,
    output trace_valid, trace_pc, trace_instr, trace_wen, trace_wd, trace_wdata,
    output commit_stall, overflow, drop_cnt, retired_cnt
`ifdef TRACE_TIMESTAMP_EN
    , output trace_cycle
`endif
  );
endinterface

// File: rtl/commit_trace_buffer.sv
// Queues WB-stage commits as trace entries and drains them to the trace sink.
// Optional TRACE_TIMESTAMP_EN adds a per-entry 64-bit cycle stamp on trace_cycle.
module commit_trace_buffer #(
  parameter int DEPTH        = 8,
  parameter int STALL_MARGIN = 2,
  parameter int CNT_W        = 32
) (
  input logic          clk,
  input logic          rst,
  commit_trace_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);
  localparam logic [AW:0] STALL_TH = (AW+1)'(DEPTH - STALL_MARGIN);

  typedef struct packed {
`ifdef TRACE_TIMESTAMP_EN
    logic [63:0] cyc;
`endif
    logic [31:0] pc;
    logic [31:0] instr;
    logic        wen;
    logic [4:0]  wd;
    logic [31:0] wdata;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0]      occ_q, occ_d;
  logic             stall_q, stall_d;
  logic             overflow_q, overflow_d;
  logic [15:0]      drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0] retired_cnt_q, retired_cnt_d;
`ifdef TRACE_TIMESTAMP_EN
  logic [63:0]      cycle_q, cycle_d;
`endif

  logic   valid, full, push, pop, drop;
  entry_t new_e, head_e;

  assign valid = (occ_q != '0);
  assign full  = (occ_q == FULL_OCC);
  assign pop   = valid && bus.trace_ready;
  assign push  = bus.commit_valid && (!full || pop);
  assign drop  = bus.commit_valid && full && !pop;

  always_comb begin
    new_e       = '0;
`ifdef TRACE_TIMESTAMP_EN
    new_e.cyc   = cycle_q;
`endif
    new_e.pc    = bus.commit_pc;
    new_e.instr = bus.commit_instr;
    new_e.wen   = bus.wb_wreg && (bus.wb_wd != 5'd0);
    new_e.wd    = bus.wb_wd;
    new_e.wdata = bus.wb_wdata;
  end

  always_comb begin
    mem_d         = mem_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    occ_d         = occ_q;
    overflow_d    = overflow_q;
    drop_cnt_d    = drop_cnt_q;
    retired_cnt_d = retired_cnt_q;
`ifdef TRACE_TIMESTAMP_EN
    cycle_d       = cycle_q + 64'd1;
`endif
    if (push) begin
      mem_d[wr_ptr_q] = new_e;
      wr_ptr_d        = wr_ptr_q + AW'(1);
      retired_cnt_d   = retired_cnt_q + CNT_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   occ_d = occ_q + (AW+1)'(1);
      2'b01:   occ_d = occ_q - (AW+1)'(1);
      default: occ_d = occ_q;
    endcase
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end
    // Registered so the pipeline sees a clean flop; the margin covers the one-cycle lag.
    stall_d = (occ_d >= STALL_TH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      occ_q         <= '0;
      stall_q       <= 1'b0;
      overflow_q    <= 1'b0;
      drop_cnt_q    <= '0;
      retired_cnt_q <= '0;
`ifdef TRACE_TIMESTAMP_EN
      cycle_q       <= '0;
`endif
    end else begin
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      occ_q         <= occ_d;
      stall_q       <= stall_d;
      overflow_q    <= overflow_d;
      drop_cnt_q    <= drop_cnt_d;
      retired_cnt_q <= retired_cnt_d;
`ifdef TRACE_TIMESTAMP_EN
      cycle_q       <= cycle_d;
`endif
    end
  end

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_e = valid ? mem_q[rd_ptr_q] : '0;

  assign bus.trace_valid  = valid;
  assign bus.trace_pc     = head_e.pc;
  assign bus.trace_instr  = head_e.instr;
  assign bus.trace_wen    = head_e.wen;
  assign bus.trace_wd     = head_e.wd;
  assign bus.trace_wdata  = head_e.wdata;
  assign bus.commit_stall = stall_q;
  assign bus.overflow     = overflow_q;
  assign bus.drop_cnt     = drop_cnt_q;
  assign bus.retired_cnt  = retired_cnt_q;
`ifdef TRACE_TIMESTAMP_EN
  assign bus.trace_cycle  = head_e.cyc;
`endif
endmodule

// File: tb/tb_commit_trace_buffer.sv
// Randomized and directed bench for commit_trace_buffer against a queue-based model.
module tb_commit_trace_buffer;
  localparam int DEPTH = 8;
  localparam int MARGIN = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  commit_trace_if #(.CNT_W(32)) bus();

  commit_trace_buffer #(.DEPTH(DEPTH), .STALL_MARGIN(MARGIN), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        wen;
    logic [4:0]  wd;
    logic [31:0] wdata;
    logic [63:0] cyc;
  } ent_t;

  ent_t        m_q[$];
  logic        m_stall, m_ovf;
  logic [15:0] m_drop;
  logic [31:0] m_ret;
  logic [63:0] m_cycle;
  bit          started = 0;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain queue semantics evaluated at each rising edge.
  always @(posedge clk) begin
    bit   do_pop, do_push, is_full;
    ent_t e;
    started <= 1;
    if (rst) begin
      m_q.delete();
      m_stall = 0; m_ovf = 0; m_drop = 0; m_ret = 0; m_cycle = 0;
    end else begin
      do_pop  = (m_q.size() > 0) && bus.trace_ready;
      is_full = (m_q.size() == DEPTH);
      do_push = bus.commit_valid && (!is_full || do_pop);
      e.pc = bus.commit_pc; e.instr = bus.commit_instr;
      e.wen = bus.wb_wreg && (bus.wb_wd != 0);
      e.wd = bus.wb_wd; e.wdata = bus.wb_wdata; e.cyc = m_cycle;
      if (do_pop) void'(m_q.pop_front());
      if (do_push) begin
        m_q.push_back(e);
        m_ret = m_ret + 1;
      end
      if (bus.commit_valid && !do_push) begin
        m_ovf = 1;
        if (m_drop != 16'hFFFF) m_drop = m_drop + 1;
      end
      m_stall = (m_q.size() >= DEPTH - MARGIN);
      m_cycle = m_cycle + 1;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      ent_t h;
      h = '{default: '0};
      if (m_q.size() > 0) h = m_q[0];
      chk("trace_valid", 64'(bus.trace_valid), 64'(m_q.size() > 0));
      chk("trace_pc", 64'(bus.trace_pc), 64'(h.pc));
      chk("trace_instr", 64'(bus.trace_instr), 64'(h.instr));
      chk("trace_wen", 64'(bus.trace_wen), 64'(h.wen));
      chk("trace_wd", 64'(bus.trace_wd), 64'(h.wd));
      chk("trace_wdata", 64'(bus.trace_wdata), 64'(h.wdata));
      chk("commit_stall", 64'(bus.commit_stall), 64'(m_stall));
      chk("overflow", 64'(bus.overflow), 64'(m_ovf));
      chk("drop_cnt", 64'(bus.drop_cnt), 64'(m_drop));
      chk("retired_cnt", 64'(bus.retired_cnt), 64'(m_ret));
`ifdef TRACE_TIMESTAMP_EN
      chk("trace_cycle", bus.trace_cycle, h.cyc);
`endif
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic commit(input logic [31:0] pc, input logic [31:0] instr,
                        input logic wreg, input logic [4:0] wd, input logic [31:0] wdata);
    bus.commit_valid = 1; bus.commit_pc = pc; bus.commit_instr = instr;
    bus.wb_wreg = wreg; bus.wb_wd = wd; bus.wb_wdata = wdata;
  endtask

  task automatic do_reset();
    rst = 1; bus.commit_valid = 0;
    tick(); tick();
    rst = 0;
  endtask

  initial begin
    rst = 1;
    bus.commit_valid = 0; bus.commit_pc = 0; bus.commit_instr = 0;
    bus.wb_wreg = 0; bus.wb_wd = 0; bus.wb_wdata = 0; bus.trace_ready = 0;
    tick(); tick(); tick();
    chk("reset trace_valid", 64'(bus.trace_valid), 64'd0);
    chk("reset retired_cnt", 64'(bus.retired_cnt), 64'd0);
    rst = 0;

    // Timestamped commits at cycles 3 and 7, sink stalled.
    for (int i = 0; i < 8; i++) begin
      if (i == 3 || i == 7) commit(32'h3000 + 32'(i), 32'h13, 0, 0, 0);
      else bus.commit_valid = 0;
      tick();
    end
    bus.commit_valid = 0;
`ifdef TRACE_TIMESTAMP_EN
    chk("ts first", bus.trace_cycle, 64'd3);
`endif
    chk("ts first pc", 64'(bus.trace_pc), 64'h3003);
    bus.trace_ready = 1;
    tick();
`ifdef TRACE_TIMESTAMP_EN
    chk("ts second", bus.trace_cycle, 64'd7);
`endif
    chk("ts second pc", 64'(bus.trace_pc), 64'h3007);
    tick();
    chk("ts drained", 64'(bus.trace_valid), 64'd0);

    // Single commit with one-cycle visibility.
    do_reset();
    bus.trace_ready = 1;
    commit(32'h1c000000, 32'h02800c0c, 1, 5'd12, 32'd3);
    tick();
    bus.commit_valid = 0;
    chk("t1 valid", 64'(bus.trace_valid), 64'd1);
    chk("t1 pc", 64'(bus.trace_pc), 64'h1c000000);
    chk("t1 instr", 64'(bus.trace_instr), 64'h02800c0c);
    chk("t1 wen", 64'(bus.trace_wen), 64'd1);
    chk("t1 wd", 64'(bus.trace_wd), 64'd12);
    chk("t1 wdata", 64'(bus.trace_wdata), 64'd3);
    tick();
    chk("t1 valid after", 64'(bus.trace_valid), 64'd0);
    chk("t1 retired", 64'(bus.retired_cnt), 64'd1);

    // r0 write clears wen.
    commit(32'h1c000004, 32'h0, 1, 5'd0, 32'd5);
    tick();
    bus.commit_valid = 0;
    chk("t2 wen", 64'(bus.trace_wen), 64'd0);
    chk("t2 wd", 64'(bus.trace_wd), 64'd0);
    chk("t2 wdata", 64'(bus.trace_wdata), 64'd5);
    tick();

    // Fill with sink stalled, then one drop.
    bus.trace_ready = 0;
    for (int i = 0; i < 8; i++) begin
      commit(32'h1000 + 32'(4 * i), 32'(i), 1, 5'(i + 1), 32'(i));
      tick();
      chk("t3 stall", 64'(bus.commit_stall), 64'(i >= 5));
    end
    commit(32'hdead, 32'h0, 0, 0, 0);
    tick();
    chk("t3 overflow", 64'(bus.overflow), 64'd1);
    chk("t3 drop_cnt", 64'(bus.drop_cnt), 64'd1);
    chk("t3 retired", 64'(bus.retired_cnt), 64'd10);

    // Full with simultaneous push and pop.
    commit(32'h2000, 32'h0, 0, 0, 0);
    bus.trace_ready = 1;
    tick();
    bus.commit_valid = 0;
    chk("t4 drop_cnt", 64'(bus.drop_cnt), 64'd1);
    chk("t4 stall", 64'(bus.commit_stall), 64'd1);
    for (int k = 0; k < 8; k++) begin
      chk("t4 order", 64'(bus.trace_pc), (k < 7) ? 64'h1004 + 64'(4 * k) : 64'h2000);
      tick();
    end
    chk("t4 empty", 64'(bus.trace_valid), 64'd0);

    // Reset with five entries queued.
    bus.trace_ready = 0;
    for (int i = 0; i < 5; i++) begin
      commit(32'h4000 + 32'(4 * i), 32'h0, 0, 0, 0);
      tick();
    end
    rst = 1; bus.commit_valid = 0;
    tick();
    chk("t5 valid", 64'(bus.trace_valid), 64'd0);
    chk("t5 retired", 64'(bus.retired_cnt), 64'd0);
    chk("t5 drop", 64'(bus.drop_cnt), 64'd0);
    chk("t5 overflow", 64'(bus.overflow), 64'd0);
    rst = 0;

    // Randomized traffic, occasionally resetting.
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 599) == 0);
      bus.commit_valid = ($urandom_range(0, 99) < 60);
      bus.commit_pc    = $urandom;
      bus.commit_instr = $urandom;
      bus.wb_wreg      = $urandom_range(0, 1);
      bus.wb_wd        = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      bus.wb_wdata     = $urandom;
      bus.trace_ready  = ($urandom_range(0, 99) < ((c / 500) % 2 ? 30 : 70));
      tick();
    end
    rst = 0; bus.commit_valid = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
